// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage.
// Holds the MEM/WB register, waits for the data-SRAM response of a load, extracts and
// extends the loaded byte/half/word, and drives the register-file and HI/LO write ports.
// wb_allowin back-pressures the earlier stages while a load response is outstanding.
module wb_stage #(
  parameter int          REG_ADDR_W = 7,
  parameter logic [31:0] RESET_PC   = 32'hbfc00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_M,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic [2:0]            MemReadType,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic [31:0]           ALUoutM,
  input  logic                  HI_LO_write_enableM,
  input  logic [63:0]           HI_LO_dataM,
  input  logic [31:0]           PCM,
  input  logic                  flush_W,
  input  logic [31:0]           data_rdata,
  input  logic                  data_data_ok,
  output logic                  wb_allowin,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic [31:0]           ResultW,
  output logic                  HI_LO_write_enable_from_WB,
  output logic [63:0]           HI_LO_data,
  output logic [31:0]           debug_wb_pc
);

  // IDLE: no pending load, WAIT: load response outstanding,
  // READY: load data buffered, DRAIN: flushed load whose response is still owed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic                  wb_valid_reg, wb_valid_next;
  logic                  reg_write_reg;
  logic                  mem_to_reg_reg;
  logic                  hilo_we_reg;
  logic [2:0]            read_type_reg;
  logic [REG_ADDR_W-1:0] write_reg_reg;
  logic [31:0]           alu_out_reg;
  logic [31:0]           pc_reg;
  logic [31:0]           rbuf_reg;
  logic [63:0]           hilo_data_reg;

  logic                  capture;
  logic                  rbuf_load;
  logic                  commit;
  logic [7:0]            rbuf_bytes [4];
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           load_data;

  // Byte lanes of the buffered load word, indexed by the address offset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign rbuf_bytes[gi] = rbuf_reg[gi*8 +: 8];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic, handshake and register load enables.
  always_comb begin
    state_next    = state_reg;
    wb_valid_next = wb_valid_reg;
    wb_allowin    = 1'b0;
    capture       = 1'b0;
    rbuf_load     = 1'b0;
    case (state_reg)
      IDLE, READY: begin
        // WB is free (or its load commits this cycle): take whatever MEM offers.
        wb_allowin    = 1'b1;
        capture       = valid_M;
        wb_valid_next = valid_M;
        if (valid_M && MemtoRegM) begin
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (data_data_ok) begin
          if (flush_W) begin
            // Killed in the same cycle the data arrived: nothing is owed any more.
            state_next    = IDLE;
            wb_valid_next = 1'b0;
          end else begin
            rbuf_load  = 1'b1;
            state_next = READY;
          end
        end else if (flush_W) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (data_data_ok) begin
          state_next    = IDLE;
          wb_valid_next = 1'b0;
        end
      end
      default: begin
        state_next    = IDLE;
        wb_valid_next = 1'b0;
      end
    endcase
  end

  // MEM/WB register and load-data buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_reg   <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      hilo_we_reg    <= 1'b0;
      read_type_reg  <= 3'd0;
      write_reg_reg  <= '0;
      alu_out_reg    <= 32'd0;
      pc_reg         <= RESET_PC;
      rbuf_reg       <= 32'd0;
      hilo_data_reg  <= 64'd0;
    end else begin
      wb_valid_reg <= wb_valid_next;
      if (capture) begin
        reg_write_reg  <= RegWriteM;
        mem_to_reg_reg <= MemtoRegM;
        hilo_we_reg    <= HI_LO_write_enableM;
        read_type_reg  <= MemReadType;
        write_reg_reg  <= WriteRegM;
        alu_out_reg    <= ALUoutM;
        pc_reg         <= PCM;
        hilo_data_reg  <= HI_LO_dataM;
      end
      if (rbuf_load) begin
        rbuf_reg <= data_rdata;
      end
    end
  end

  // Load extraction: select byte/half by the address offset and extend.
  always_comb begin
    sel_byte = rbuf_bytes[alu_out_reg[1:0]];
    sel_half = alu_out_reg[1] ? rbuf_reg[31:16] : rbuf_reg[15:0];
    case (read_type_reg)
      3'b000:  load_data = rbuf_reg;
      3'b001:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b010:  load_data = {24'd0, sel_byte};
      3'b011:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {16'd0, sel_half};
      default: load_data = rbuf_reg;
    endcase
  end

  // Commit and write-port outputs; enables and data are zero without a commit.
  always_comb begin
    commit = wb_valid_reg & ~flush_W &
             (((state_reg == IDLE) & ~mem_to_reg_reg) | (state_reg == READY));
    RegWriteW                  = commit & reg_write_reg & (write_reg_reg != '0);
    HI_LO_write_enable_from_WB = commit & hilo_we_reg;
    ResultW                    = 32'd0;
    if (commit) begin
      ResultW = mem_to_reg_reg ? load_data : alu_out_reg;
    end
  end

  assign WriteRegW   = write_reg_reg;
  assign HI_LO_data  = hilo_data_reg;
  assign debug_wb_pc = pc_reg;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: transaction-level randomized bench for wb_stage.
// Each instruction is driven as a whole transaction (idle gap, issue, load wait with
// optional flush, response); the expected commit is computed from the load/extend
// rules with plain arithmetic and checked in the cycle after the transaction ends.
module tb_wb_stage;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic        clk;
  logic        rst;
  logic        valid_M;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic [2:0]  MemReadType;
  logic [6:0]  WriteRegM;
  logic [31:0] ALUoutM;
  logic        HI_LO_write_enableM;
  logic [63:0] HI_LO_dataM;
  logic [31:0] PCM;
  logic        flush_W;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        wb_allowin;
  logic        RegWriteW;
  logic [6:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        HI_LO_write_enable_from_WB;
  logic [63:0] HI_LO_data;
  logic [31:0] debug_wb_pc;

  wb_stage #(.REG_ADDR_W(7), .RESET_PC(RESET_PC)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .valid_M                    (valid_M),
    .RegWriteM                  (RegWriteM),
    .MemtoRegM                  (MemtoRegM),
    .MemReadType                (MemReadType),
    .WriteRegM                  (WriteRegM),
    .ALUoutM                    (ALUoutM),
    .HI_LO_write_enableM        (HI_LO_write_enableM),
    .HI_LO_dataM                (HI_LO_dataM),
    .PCM                        (PCM),
    .flush_W                    (flush_W),
    .data_rdata                 (data_rdata),
    .data_data_ok               (data_data_ok),
    .wb_allowin                 (wb_allowin),
    .RegWriteW                  (RegWriteW),
    .WriteRegW                  (WriteRegW),
    .ResultW                    (ResultW),
    .HI_LO_write_enable_from_WB (HI_LO_write_enable_from_WB),
    .HI_LO_data                 (HI_LO_data),
    .debug_wb_pc                (debug_wb_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ld;
    logic [2:0]  rt;
    logic        rw;
    logic [6:0]  wr;
    logic [31:0] alu;
    logic        hw;
    logic [63:0] hd;
    logic [31:0] pc;
    int          d;         // cycles from capture to data_ok (load only)
    int          flush_at;  // wait cycle carrying flush_W, 0 = none
    int          gap;       // idle cycles before issue
    logic [31:0] rdata;
  } txn_t;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;
  bit noise    = 1'b0;

  // Expected commit for the next cycle and last-accepted instruction fields.
  logic        cm_valid = 1'b0;
  logic        cm_rw    = 1'b0;
  logic [31:0] cm_res   = 32'd0;
  logic        cm_hw    = 1'b0;
  logic [6:0]  exp_wr   = 7'd0;
  logic [63:0] exp_hd   = 64'd0;
  logic [31:0] exp_pc   = RESET_PC;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference load extraction, from byte/half arithmetic on the response word.
  function automatic logic [31:0] load_value(input logic [2:0] t, input logic [1:0] off,
                                             input logic [31:0] w);
    longint b;
    longint h;
    longint v;
    b = longint'(w >> (int'(off) * 8)) % 256;
    h = longint'(w >> ((int'(off) / 2) * 16)) % 65536;
    case (t)
      3'd1:    v = (b >= 128) ? b - 256 : b;
      3'd2:    v = b;
      3'd3:    v = (h >= 32768) ? h - 65536 : h;
      3'd4:    v = h;
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  task automatic rand_m();
    RegWriteM           = 1'($urandom);
    MemtoRegM           = 1'($urandom);
    MemReadType         = 3'($urandom);
    WriteRegM           = 7'($urandom);
    ALUoutM             = $urandom;
    HI_LO_write_enableM = 1'($urandom);
    HI_LO_dataM         = {$urandom, $urandom};
    PCM                 = $urandom;
  endtask

  // Drive one cycle of inputs, check all outputs, then advance past the clock edge.
  task automatic run_cycle(input logic vm, input logic fl, input logic dok,
                           input logic [31:0] rd, input logic exp_allow);
    logic c;
    valid_M      = vm;
    flush_W      = fl;
    data_data_ok = dok;
    data_rdata   = rd;
    #1;
    c = cm_valid && !fl;
    check_val("wb_allowin", wb_allowin, exp_allow);
    check_val("RegWriteW", RegWriteW, c ? cm_rw : 1'b0);
    check_val("ResultW", ResultW, c ? cm_res : 32'd0);
    check_val("HI_LO_we", HI_LO_write_enable_from_WB, c ? cm_hw : 1'b0);
    check_val("WriteRegW", WriteRegW, exp_wr);
    check_val("HI_LO_data", HI_LO_data, exp_hd);
    check_val("debug_wb_pc", debug_wb_pc, exp_pc);
    cm_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic coin(input int one_in);
    return noise && ($urandom_range(0, one_in - 1) == 0);
  endfunction

  task automatic do_txn(input txn_t t);
    for (int i = 0; i < t.gap; i++) begin
      rand_m();
      run_cycle(1'b0, coin(5), coin(3), $urandom, 1'b1);
    end
    RegWriteM           = t.rw;
    MemtoRegM           = t.ld;
    MemReadType         = t.rt;
    WriteRegM           = t.wr;
    ALUoutM             = t.alu;
    HI_LO_write_enableM = t.hw;
    HI_LO_dataM         = t.hd;
    PCM                 = t.pc;
    run_cycle(1'b1, coin(5), coin(3), $urandom, 1'b1);
    exp_wr = t.wr;
    exp_hd = t.hd;
    exp_pc = t.pc;
    if (t.ld) begin
      for (int c = 1; c <= t.d; c++) begin
        if (noise) rand_m();
        run_cycle(coin(2), (c == t.flush_at), (c == t.d),
                  (c == t.d) ? t.rdata : $urandom, 1'b0);
      end
    end
    if (!t.ld || t.flush_at == 0) begin
      cm_valid = 1'b1;
      cm_rw    = t.rw && (t.wr != 7'd0);
      cm_res   = t.ld ? load_value(t.rt, t.alu[1:0], t.rdata) : t.alu;
      cm_hw    = t.hw;
    end
    n_txn++;
    $display("txn %0d: load=%0d type=%0d rd=%0d d=%0d flush_at=%0d commit=%0d res=%h",
             n_txn, t.ld, t.rt, t.wr, t.d, t.flush_at, cm_valid, cm_res);
  endtask

  function automatic txn_t base_txn();
    txn_t t;
    t.ld = 1'b0; t.rt = 3'd0; t.rw = 1'b1; t.wr = 7'd1; t.alu = 32'd0;
    t.hw = 1'b0; t.hd = 64'd0; t.pc = 32'hbfc00100; t.d = 1; t.flush_at = 0;
    t.gap = 0; t.rdata = 32'd0;
    return t;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_RegWriteW"}, RegWriteW, 1'b0);
    check_val({tag, "_ResultW"}, ResultW, 32'd0);
    check_val({tag, "_HI_LO_we"}, HI_LO_write_enable_from_WB, 1'b0);
    check_val({tag, "_WriteRegW"}, WriteRegW, 7'd0);
    check_val({tag, "_HI_LO_data"}, HI_LO_data, 64'd0);
    check_val({tag, "_pc"}, debug_wb_pc, RESET_PC);
    check_val({tag, "_allowin"}, wb_allowin, 1'b1);
  endtask

  initial begin
    txn_t t;
    rst = 1'b1;
    valid_M = 1'b0; flush_W = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    RegWriteM = 1'b0; MemtoRegM = 1'b0; MemReadType = 3'd0; WriteRegM = 7'd0;
    ALUoutM = 32'd0; HI_LO_write_enableM = 1'b0; HI_LO_dataM = 64'd0; PCM = 32'd0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Directed: ADDU r5.
    t = base_txn(); t.wr = 7'd5; t.alu = 32'h1234; do_txn(t);
    // LB / LBU r3, offset 2, response 3 cycles later.
    t = base_txn(); t.ld = 1'b1; t.rt = 3'd1; t.wr = 7'd3; t.alu = 32'h1000_0002;
    t.d = 3; t.rdata = 32'h0080FF11; do_txn(t);
    t.rt = 3'd2; do_txn(t);
    // LHU / LH offset 2, minimum latency.
    t = base_txn(); t.ld = 1'b1; t.rt = 3'd4; t.wr = 7'd7; t.alu = 32'h2000_0002;
    t.d = 1; t.rdata = 32'h9ABC0000; do_txn(t);
    t.rt = 3'd3; do_txn(t);
    // Load flushed in WAIT, response later; then flush coinciding with response.
    t = base_txn(); t.ld = 1'b1; t.wr = 7'd9; t.d = 3; t.flush_at = 1;
    t.rdata = 32'hDEADBEEF; do_txn(t);
    t.flush_at = 2; t.d = 2; do_txn(t);
    // MTHI-like HI/LO write, no GPR write; then write to $0.
    t = base_txn(); t.rw = 1'b0; t.hw = 1'b1; t.hd = 64'h1_00000002; do_txn(t);
    t = base_txn(); t.wr = 7'd0; t.alu = 32'hFFFF_0000; t.gap = 1; do_txn(t);
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Reset while a load waits for its response; a stray response afterwards is ignored.
    t = base_txn(); t.ld = 1'b1; t.wr = 7'd9; t.hd = 64'h5555_AAAA_0000_1111;
    t.pc = 32'h8000_1000; t.d = 4; t.rdata = 32'h0;
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemReadType = 3'd0; WriteRegM = t.wr;
    ALUoutM = 32'h40; HI_LO_write_enableM = 1'b0; HI_LO_dataM = t.hd; PCM = t.pc;
    run_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    exp_wr = t.wr; exp_hd = t.hd; exp_pc = t.pc;
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midwait_reset");
    exp_wr = 7'd0; exp_hd = 64'd0; exp_pc = RESET_PC; cm_valid = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    run_cycle(1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Randomized transactions with stray responses, flushes and ignored MEM traffic.
    noise = 1'b1;
    for (int i = 0; i < 150; i++) begin
      t.ld       = 1'($urandom);
      t.rt       = 3'($urandom_range(0, 7));
      t.rw       = 1'($urandom);
      t.wr       = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom);
      t.alu      = $urandom;
      t.hw       = 1'($urandom);
      t.hd       = {$urandom, $urandom};
      t.pc       = $urandom;
      t.d        = $urandom_range(1, 4);
      t.flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, t.d) : 0;
      t.gap      = $urandom_range(0, 2);
      t.rdata    = $urandom;
      do_txn(t);
    end
    noise = 1'b0;
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
